// File: rtl/pwm_ramp_ctrl.sv
// Duty-fade sequencer for one pwm_core: steps duty toward a target every
// div PWM wraps, then holds and raises a sticky done flag.
module pwm_ramp_ctrl #(
    parameter int unsigned W     = 32,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [W-1:0]     cfg_period,
    input  logic [W-1:0]     cfg_duty_start,
    input  logic [W-1:0]     cfg_duty_target,
    input  logic [W-1:0]     cfg_step,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             wrap,
    input  logic             irq_clr,
    output logic             pwm_en,
    output logic [W-1:0]     pwm_period,
    output logic [W-1:0]     pwm_duty,
    output logic             busy,
    output logic             done_irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   wcnt, wcnt_n;
    logic [DIV_W-1:0]   div_l, div_n;
    logic [W-1:0]       step_l, step_n;
    logic [W-1:0]       target_l, target_n;
    logic               up_l, up_n;
    logic               en_n, done_n, busy_n, done_set;
    logic [W-1:0]       period_n, duty_n, duty_step;

    // Saturating step toward the target; duty always lies between the
    // start and target values while ramping, so the differences never wrap.
    always_comb begin
        duty_step = pwm_duty;
        if (up_l) begin
            duty_step = ((target_l - pwm_duty) <= step_l) ? target_l : pwm_duty + step_l;
        end else begin
            duty_step = ((pwm_duty - target_l) <= step_l) ? target_l : pwm_duty - step_l;
        end
    end

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        div_n    = div_l;
        step_n   = step_l;
        target_n = target_l;
        up_n     = up_l;
        en_n     = pwm_en;
        period_n = pwm_period;
        duty_n   = pwm_duty;
        done_set = 1'b0;

        if (stop) begin
            state_n  = IDLE;
            en_n     = 1'b0;
            period_n = '0;
            duty_n   = '0;
            wcnt_n   = '0;
        end else if (start) begin
            div_n    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            step_n   = (cfg_step == '0) ? W'(1) : cfg_step;
            target_n = cfg_duty_target;
            up_n     = cfg_duty_target > cfg_duty_start;
            wcnt_n   = '0;
            en_n     = 1'b1;
            period_n = cfg_period;
            duty_n   = cfg_duty_start;
            if (cfg_duty_start == cfg_duty_target) begin
                state_n  = HOLD;
                done_set = 1'b1;
            end else begin
                state_n = RAMP;
            end
        end else if (state == RAMP && wrap) begin
            if (wcnt == div_l - DIV_W'(1)) begin
                wcnt_n = '0;
                duty_n = duty_step;
                if (duty_step == target_l) begin
                    state_n  = HOLD;
                    done_set = 1'b1;
                end
            end else begin
                wcnt_n = wcnt + DIV_W'(1);
            end
        end

        done_n = done_set ? 1'b1 : (irq_clr ? 1'b0 : done_irq);
        busy_n = (state_n == RAMP);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            wcnt       <= '0;
            div_l      <= DIV_W'(1);
            step_l     <= W'(1);
            target_l   <= '0;
            up_l       <= 1'b0;
            pwm_en     <= 1'b0;
            pwm_period <= '0;
            pwm_duty   <= '0;
            busy       <= 1'b0;
            done_irq   <= 1'b0;
        end else begin
            state      <= state_n;
            wcnt       <= wcnt_n;
            div_l      <= div_n;
            step_l     <= step_n;
            target_l   <= target_n;
            up_l       <= up_n;
            pwm_en     <= en_n;
            pwm_period <= period_n;
            pwm_duty   <= duty_n;
            busy       <= busy_n;
            done_irq   <= done_n;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: stimulus queues hand-computed output
// snapshots, a negedge monitor pops and compares them.
module tb_pwm_ramp_ctrl;

    localparam int unsigned W     = 32;
    localparam int unsigned DIV_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0, stop = 1'b0, wrap = 1'b0, irq_clr = 1'b0;
    logic [W-1:0]     cfg_period = '0, cfg_duty_start = '0, cfg_duty_target = '0, cfg_step = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             pwm_en, busy, done_irq;
    logic [W-1:0]     pwm_period, pwm_duty;

    typedef struct {
        string        name;
        logic         en;
        logic [W-1:0] period;
        logic [W-1:0] duty;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pwm_ramp_ctrl #(.W(W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .cfg_period(cfg_period), .cfg_duty_start(cfg_duty_start),
        .cfg_duty_target(cfg_duty_target), .cfg_step(cfg_step), .cfg_div(cfg_div),
        .wrap(wrap), .irq_clr(irq_clr),
        .pwm_en(pwm_en), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
        .busy(busy), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pwm_en !== e.en || pwm_period !== e.period || pwm_duty !== e.duty ||
                    busy !== e.busy || done_irq !== e.done) begin
                    errors++;
                    $display("FAIL %s: got en=%0b period=%0d duty=%0d busy=%0b done=%0b, expected en=%0b period=%0d duty=%0d busy=%0b done=%0b",
                             e.name, pwm_en, pwm_period, pwm_duty, busy, done_irq,
                             e.en, e.period, e.duty, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start   = 1'b0;
        stop    = 1'b0;
        wrap    = 1'b0;
        irq_clr = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic en, input logic [W-1:0] period,
                              input logic [W-1:0] duty, input logic b, input logic d);
        exp_t e;
        e.name = name; e.en = en; e.period = period; e.duty = duty; e.busy = b; e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input logic [W-1:0] per, input logic [W-1:0] ds, input logic [W-1:0] dt,
                           input logic [W-1:0] st, input logic [DIV_W-1:0] dv);
        cfg_period = per; cfg_duty_start = ds; cfg_duty_target = dt; cfg_step = st; cfg_div = dv;
    endtask

    task automatic do_wrap();
        wrap = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        expect_out("reset", 0, 0, 0, 0, 0);
        rstn = 1'b1;
        tick();
        expect_out("idle_after_reset", 0, 0, 0, 0, 0);
        do_wrap();
        expect_out("idle_wrap_ignored", 0, 0, 0, 0, 0);

        // T1 up ramp with shadowing check
        set_cfg(99, 10, 40, 10, 2);
        start = 1'b1; tick();
        expect_out("t1_start", 1, 99, 10, 1, 0);
        set_cfg(7, 0, 200, 1, 5);
        do_wrap(); expect_out("t1_w1", 1, 99, 10, 1, 0);
        tick();
        do_wrap(); expect_out("t1_w2", 1, 99, 20, 1, 0);
        do_wrap(); expect_out("t1_w3", 1, 99, 20, 1, 0);
        do_wrap(); expect_out("t1_w4", 1, 99, 30, 1, 0);
        do_wrap(); expect_out("t1_w5", 1, 99, 30, 1, 0);
        do_wrap(); expect_out("t1_w6_done", 1, 99, 40, 0, 1);
        do_wrap(); expect_out("t1_hold_wrap", 1, 99, 40, 0, 1);
        irq_clr = 1'b1; tick();
        expect_out("t1_irq_clr", 1, 99, 40, 0, 0);

        // T2 down ramp, non-multiple step
        set_cfg(77, 50, 5, 20, 1);
        start = 1'b1; tick();
        expect_out("t2_start", 1, 77, 50, 1, 0);
        do_wrap(); expect_out("t2_w1", 1, 77, 30, 1, 0);
        do_wrap(); expect_out("t2_w2", 1, 77, 10, 1, 0);
        do_wrap(); expect_out("t2_w3_sat", 1, 77, 5, 0, 1);
        do_wrap(); expect_out("t2_hold", 1, 77, 5, 0, 1);
        irq_clr = 1'b1; tick();
        expect_out("t2_irq_clr", 1, 77, 5, 0, 0);

        // T3 zero step/div treated as 1
        set_cfg(9, 0, 3, 0, 0);
        start = 1'b1; tick();
        expect_out("t3_start", 1, 9, 0, 1, 0);
        do_wrap(); expect_out("t3_w1", 1, 9, 1, 1, 0);
        do_wrap(); expect_out("t3_w2", 1, 9, 2, 1, 0);
        do_wrap(); expect_out("t3_w3_done", 1, 9, 3, 0, 1);
        irq_clr = 1'b1; tick();
        expect_out("t3_irq_clr", 1, 9, 3, 0, 0);

        // T4 start equals target
        set_cfg(50, 25, 25, 4, 3);
        start = 1'b1; tick();
        expect_out("t4_start_hold", 1, 50, 25, 0, 1);
        do_wrap(); expect_out("t4_hold_wrap", 1, 50, 25, 0, 1);
        irq_clr = 1'b1; tick();
        expect_out("t4_irq_clr", 1, 50, 25, 0, 0);

        // T5 stop mid-ramp, then start+stop together
        set_cfg(99, 10, 40, 10, 2);
        start = 1'b1; tick();
        expect_out("t5_start", 1, 99, 10, 1, 0);
        do_wrap(); do_wrap(); do_wrap();
        expect_out("t5_w3", 1, 99, 20, 1, 0);
        stop = 1'b1; tick();
        expect_out("t5_stop", 0, 0, 0, 0, 0);
        do_wrap(); expect_out("t5_idle_wrap", 0, 0, 0, 0, 0);
        start = 1'b1; stop = 1'b1; tick();
        expect_out("t5_start_stop", 0, 0, 0, 0, 0);

        // T6 irq_clr loses to done set; stop keeps done; start beats wrap; reset
        set_cfg(77, 50, 5, 20, 1);
        start = 1'b1; tick();
        do_wrap(); do_wrap();
        expect_out("t6_w2", 1, 77, 10, 1, 0);
        wrap = 1'b1; irq_clr = 1'b1; tick();
        expect_out("t6_done_beats_clr", 1, 77, 5, 0, 1);
        stop = 1'b1; tick();
        expect_out("t6_stop_keeps_done", 0, 0, 0, 0, 1);
        set_cfg(99, 10, 40, 10, 2);
        start = 1'b1; wrap = 1'b1; tick();
        expect_out("t6_start_beats_wrap", 1, 99, 10, 1, 1);
        do_wrap(); expect_out("t6_wrap1_after", 1, 99, 10, 1, 1);
        do_wrap(); expect_out("t6_wrap2_after", 1, 99, 20, 1, 1);
        rstn = 1'b0; tick();
        expect_out("t6_reset_mid_ramp", 0, 0, 0, 0, 0);
        rstn = 1'b1;

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
